// File: rtl/tsu_queue_arb.sv
// -----------------------------------------------------------------------------
// tsu_queue_arb
//
// Purpose:
//   Drains the RX and TX tsu timestamp queues through their read ports and
//   presents the captured entries as one valid/ready stream tagged with the
//   source queue. Each read is sequenced as: rd_en pulse, fixed read latency,
//   capture, hold until accepted. When both queues hold entries the source is
//   chosen round-robin, or by strict TX priority when the build macro
//   TSU_ARB_TX_PRIO_EN is defined.
//
// Handshake:
//   out_valid/out_ready follow strict valid/ready rules. out_valid stays high
//   with out_data/out_src stable until a rising edge where out_ready is also
//   high; that edge transfers the entry. out_valid never depends on out_ready.
//
// Ports:
//   q_rd_clk      in   clock, rising edge
//   q_rst         in   synchronous reset, active-high
//   rx_q_rd_stat  in   RX queue occupancy (0 = empty)
//   rx_q_rd_data  in   RX queue read data
//   rx_q_rd_en    out  RX queue read strobe, one-cycle pulse
//   tx_q_rd_stat  in   TX queue occupancy (0 = empty)
//   tx_q_rd_data  in   TX queue read data
//   tx_q_rd_en    out  TX queue read strobe, one-cycle pulse
//   out_valid     out  captured entry available
//   out_ready     in   consumer accepts the entry
//   out_src       out  0 = RX, 1 = TX
//   out_data      out  captured timestamp entry
//   rx_cnt        out  RX entries delivered (wrapping)
//   tx_cnt        out  TX entries delivered (wrapping)
//   o_dbg_state   out  current FSM state (IDLE=0, RD=1, WAIT=2, HOLD=3)
//
// Build option:
//   TSU_ARB_TX_PRIO_EN - strict TX priority instead of round-robin.
// -----------------------------------------------------------------------------
module tsu_queue_arb #(
    parameter int DATA_W = 56,
    parameter int STAT_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              q_rd_clk,
    input  logic              q_rst,
    input  logic [STAT_W-1:0] rx_q_rd_stat,
    input  logic [DATA_W-1:0] rx_q_rd_data,
    output logic              rx_q_rd_en,
    input  logic [STAT_W-1:0] tx_q_rd_stat,
    input  logic [DATA_W-1:0] tx_q_rd_data,
    output logic              tx_q_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_src,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  tx_cnt,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // RD_LAT is at most 4, so the wait counter never exceeds 3.
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sel;       // 0 = RX, 1 = TX; fixed from IDLE to HOLD
    logic                w_sel_nxt;
    logic                r_rr;        // source favoured on the next tie
    logic [2:0]          r_wait_cnt;
    logic                r_out_valid;
    logic                r_out_src;
    logic [DATA_W-1:0]   r_out_data;
    logic [CNT_W-1:0]    r_rx_cnt;
    logic [CNT_W-1:0]    r_tx_cnt;

    logic                w_rx_req;
    logic                w_tx_req;
    logic                w_pick_tx;

    assign w_rx_req = (rx_q_rd_stat != '0);
    assign w_tx_req = (tx_q_rd_stat != '0);

`ifdef TSU_ARB_TX_PRIO_EN
    // TX wins every tie; the round-robin pointer stays parked at RX.
    assign w_pick_tx = w_tx_req;
`else
    // TX only when it is the sole requester, or on a tie when it is its turn.
    assign w_pick_tx = w_tx_req && (!w_rx_req || r_rr);
`endif

    // State register
    always_ff @(posedge q_rd_clk) begin
        if (q_rst) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Next-state and read strobes
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        rx_q_rd_en  = 1'b0;
        tx_q_rd_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_req || w_tx_req) begin
                    w_state_nxt = S_RD;
                    w_sel_nxt   = w_pick_tx;
                end
            end
            S_RD: begin
                rx_q_rd_en  = !r_sel;
                tx_q_rd_en  = r_sel;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // out_valid is always high in HOLD.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latency counter, capture register, counters, RR pointer
    always_ff @(posedge q_rd_clk) begin
        if (q_rst) begin
            r_wait_cnt  <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
            r_out_data  <= '0;
            r_rx_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_rr        <= 1'b0;
        end else begin
            case (r_state)
                S_RD: begin
                    r_wait_cnt <= LAT_M1;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_out_data  <= r_sel ? tx_q_rd_data : rx_q_rd_data;
                        r_out_src   <= r_sel;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_sel) begin
                            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                        end else begin
                            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                        end
`ifndef TSU_ARB_TX_PRIO_EN
                        r_rr <= !r_sel;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_src     = r_out_src;
    assign out_data    = r_out_data;
    assign rx_cnt      = r_rx_cnt;
    assign tx_cnt      = r_tx_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tsu_queue_arb.sv
// -----------------------------------------------------------------------------
// tb_tsu_queue_arb
//
// Two instances share one clock:
//   u_a : RD_LAT=1, CNT_W=16 (reset, single entry, arbitration, backpressure)
//   u_b : RD_LAT=3, CNT_W=4  (read latency window, counter wrap, reset in WAIT)
// Inputs change 1 ns after each rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_tsu_queue_arb;

    localparam int DATA_W = 56;
    localparam int STAT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A signals ----------------
    logic              a_rst;
    logic [STAT_W-1:0] a_rx_stat, a_tx_stat;
    logic [DATA_W-1:0] a_rx_data, a_tx_data;
    logic              a_rx_en, a_tx_en;
    logic              a_valid, a_ready, a_src;
    logic [DATA_W-1:0] a_data;
    logic [15:0]       a_rx_cnt, a_tx_cnt;
    logic [1:0]        a_state;

    // ---------------- instance B signals ----------------
    logic              b_rst;
    logic [STAT_W-1:0] b_rx_stat, b_tx_stat;
    logic [DATA_W-1:0] b_rx_data, b_tx_data;
    logic              b_rx_en, b_tx_en;
    logic              b_valid, b_ready, b_src;
    logic [DATA_W-1:0] b_data;
    logic [3:0]        b_rx_cnt, b_tx_cnt;
    logic [1:0]        b_state;

    tsu_queue_arb #(.DATA_W(DATA_W), .STAT_W(STAT_W), .RD_LAT(1), .CNT_W(16)) u_a (
        .q_rd_clk(clk), .q_rst(a_rst),
        .rx_q_rd_stat(a_rx_stat), .rx_q_rd_data(a_rx_data), .rx_q_rd_en(a_rx_en),
        .tx_q_rd_stat(a_tx_stat), .tx_q_rd_data(a_tx_data), .tx_q_rd_en(a_tx_en),
        .out_valid(a_valid), .out_ready(a_ready), .out_src(a_src), .out_data(a_data),
        .rx_cnt(a_rx_cnt), .tx_cnt(a_tx_cnt), .o_dbg_state(a_state)
    );

    tsu_queue_arb #(.DATA_W(DATA_W), .STAT_W(STAT_W), .RD_LAT(3), .CNT_W(4)) u_b (
        .q_rd_clk(clk), .q_rst(b_rst),
        .rx_q_rd_stat(b_rx_stat), .rx_q_rd_data(b_rx_data), .rx_q_rd_en(b_rx_en),
        .tx_q_rd_stat(b_tx_stat), .tx_q_rd_data(b_tx_data), .tx_q_rd_en(b_tx_en),
        .out_valid(b_valid), .out_ready(b_ready), .out_src(b_src), .out_data(b_data),
        .rx_cnt(b_rx_cnt), .tx_cnt(b_tx_cnt), .o_dbg_state(b_state)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration order for two entries in each queue (bit k = source of read k).
    logic [3:0] exp_order;
    logic       src;
    logic [DATA_W-1:0] held;

    initial begin
`ifdef TSU_ARB_TX_PRIO_EN
        exp_order = 4'b0011;  // TX, TX, RX, RX
`else
        exp_order = 4'b1010;  // RX, TX, RX, TX
`endif
        // ---------------- reset with both queues non-empty ----------------
        a_rst = 1'b1; a_rx_stat = 8'd3; a_tx_stat = 8'd3;
        a_rx_data = '0; a_tx_data = '0; a_ready = 1'b1;
        b_rst = 1'b1; b_rx_stat = 8'd3; b_tx_stat = 8'd3;
        b_rx_data = '0; b_tx_data = '0; b_ready = 1'b1;
        tick();
        tick();
        check("rst_rx_en",  a_rx_en, 0);
        check("rst_tx_en",  a_tx_en, 0);
        check("rst_valid",  a_valid, 0);
        check("rst_src",    a_src, 0);
        check("rst_data",   a_data, 0);
        check("rst_rx_cnt", a_rx_cnt, 0);
        check("rst_tx_cnt", a_tx_cnt, 0);
        check("rst_state",  a_state, ST_IDLE);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_en",   {b_rx_en, b_tx_en}, 0);

        a_rst = 1'b0;
        b_rst = 1'b0; b_rx_stat = 8'd0; b_tx_stat = 8'd0;
        check("rel_idle_rx_en", a_rx_en, 0);
        tick();
        check("rel_rd_rx_en", a_rx_en, 1);
        check("rel_rd_tx_en", a_tx_en, 0);
        check("rel_rd_state", a_state, ST_RD);

        // reset while in RD aborts the read
        a_rst = 1'b1; a_rx_stat = 8'd0; a_tx_stat = 8'd0;
        tick();
        check("abort_rd_state", a_state, ST_IDLE);
        check("abort_rd_en",    a_rx_en, 0);
        a_rst = 1'b0;
        tick();
        check("abort_rd_valid", a_valid, 0);
        check("abort_rd_idle_en", {a_rx_en, a_tx_en}, 0);

        // ---------------- single RX entry, RD_LAT=1 ----------------
        a_rx_stat = 8'd1;                       // request cycle n
        tick();                                  // n+1
        check("rx1_rd_en", a_rx_en, 1);
        check("rx1_no_tx", a_tx_en, 0);
        a_rx_stat = 8'd0;
        a_rx_data = 56'hEE_EEEE_EEEE_EEEE;
        tick();                                  // n+2
        check("rx1_wait_en", {a_rx_en, a_tx_en}, 0);
        check("rx1_wait_valid", a_valid, 0);
        a_rx_data = 56'h00_1234_5678_9ABC;
        tick();                                  // n+3
        check("rx1_valid", a_valid, 1);
        check("rx1_src",   a_src, 0);
        check("rx1_data",  a_data, 56'h00_1234_5678_9ABC);
        check("rx1_hold_en", {a_rx_en, a_tx_en}, 0);
        a_rx_data = 56'h11_1111_1111_1111;
        tick();                                  // n+4
        check("rx1_drop", a_valid, 0);
        check("rx1_rx_cnt", a_rx_cnt, 1);
        check("rx1_tx_cnt", a_tx_cnt, 0);

        // ---------------- both queues hold two entries ----------------
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        a_rx_stat = 8'd2; a_tx_stat = 8'd2;
        a_rx_data = 56'h00_0000_0000_00A0;
        a_tx_data = 56'h00_0000_0000_00B0;
        for (int k = 0; k < 4; k++) begin
            src = exp_order[k];
            tick();                              // RD
            check("arb_rx_en", a_rx_en, !src);
            check("arb_tx_en", a_tx_en, src);
            if (src) a_tx_stat = a_tx_stat - 8'd1;
            else     a_rx_stat = a_rx_stat - 8'd1;
            tick();                              // WAIT
            tick();                              // HOLD
            check("arb_valid", a_valid, 1);
            check("arb_src",   a_src, src);
            check("arb_data",  a_data, src ? 56'hB0 : 56'hA0);
            tick();                              // IDLE
        end
        check("arb_rx_cnt", a_rx_cnt, 2);
        check("arb_tx_cnt", a_tx_cnt, 2);
        tick();
        check("arb_empty_en", {a_rx_en, a_tx_en}, 0);
        check("arb_empty_state", a_state, ST_IDLE);

        // ---------------- backpressure ----------------
        a_ready = 1'b0;
        a_rx_stat = 8'd1;
        tick();                                  // RD
        check("bp_rd_en", a_rx_en, 1);
        a_rx_stat = 8'd0;
        a_rx_data = 56'h00_CAFE_F00D_1234;
        tick();                                  // WAIT
        tick();                                  // HOLD
        check("bp_valid0", a_valid, 1);
        held = 56'h00_CAFE_F00D_1234;
        a_rx_stat = 8'd1; a_tx_stat = 8'd1;      // pending requests must wait
        a_rx_data = 56'hFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid",  a_valid, 1);
            check("bp_data",   a_data, held);
            check("bp_src",    a_src, 0);
            check("bp_no_rd",  {a_rx_en, a_tx_en}, 0);
            check("bp_rx_cnt", a_rx_cnt, 2);
            check("bp_tx_cnt", a_tx_cnt, 2);
        end
        a_ready = 1'b1;
        tick();
        check("bp_drop",   a_valid, 0);
        check("bp_rx_cnt_after", a_rx_cnt, 3);
        check("bp_state",  a_state, ST_IDLE);
        a_rx_stat = 8'd0; a_tx_stat = 8'd0;
        tick();
        check("bp_idle_en", {a_rx_en, a_tx_en}, 0);

        // ---------------- RD_LAT=3 TX entry ----------------
        b_tx_stat = 8'd1;                        // request cycle n
        tick();                                  // n+1 = c
        check("lat3_tx_en", b_tx_en, 1);
        check("lat3_rx_en", b_rx_en, 0);
        b_tx_stat = 8'd0;
        b_tx_data = 56'h00_DEAD_0000_0001;
        tick();                                  // c+1
        b_tx_data = 56'h00_DEAD_0000_0002;
        tick();                                  // c+2
        check("lat3_en_quiet", {b_rx_en, b_tx_en}, 0);
        b_tx_data = 56'h00_DEAD_0000_0003;
        tick();                                  // c+3
        check("lat3_not_yet", b_valid, 0);
        b_tx_data = 56'h00_0BAD_BEEF_0042;
        tick();                                  // c+4
        check("lat3_valid", b_valid, 1);
        check("lat3_src",   b_src, 1);
        check("lat3_data",  b_data, 56'h00_0BAD_BEEF_0042);
        b_tx_data = 56'h00_DEAD_0000_0005;
        tick();
        check("lat3_drop",   b_valid, 0);
        check("lat3_tx_cnt", b_tx_cnt, 1);
        check("lat3_rx_cnt", b_rx_cnt, 0);

        // ---------------- counter wrap (CNT_W=4) ----------------
        b_rx_data = 56'h00_0000_0000_005A;
        for (int i = 0; i < 15; i++) begin
            b_rx_stat = 8'd1;
            tick();                              // RD
            b_rx_stat = 8'd0;
            repeat (4) tick();                   // WAIT x3, HOLD
            tick();                              // accepted, IDLE
        end
        check("wrap_pre", b_rx_cnt, 4'hF);
        b_rx_stat = 8'd1;
        tick();
        check("wrap_rd_en", b_rx_en, 1);
        b_rx_stat = 8'd0;
        repeat (4) tick();
        check("wrap_valid", b_valid, 1);
        check("wrap_data",  b_data, 56'h5A);
        tick();
        check("wrap_rx_cnt", b_rx_cnt, 0);
        check("wrap_tx_cnt", b_tx_cnt, 1);

        // ---------------- reset during WAIT ----------------
        b_rx_stat = 8'd1;
        tick();                                  // RD
        b_rx_stat = 8'd0;
        tick();                                  // WAIT
        check("rw_in_wait", b_state, ST_WAIT);
        b_rst = 1'b1;
        tick();
        check("rw_state",  b_state, ST_IDLE);
        check("rw_valid",  b_valid, 0);
        check("rw_tx_cnt", b_tx_cnt, 0);
        b_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rw_stay_invalid", b_valid, 0);
            check("rw_stay_idle",    b_state, ST_IDLE);
        end
        b_rx_stat = 8'd1;
        tick();
        check("rw_restart_en", b_rx_en, 1);
        b_rx_stat = 8'd0;
        repeat (4) tick();
        check("rw_restart_valid", b_valid, 1);
        tick();
        check("rw_restart_cnt", b_rx_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tsu_queue_arb.md
Name: tsu_queue_arb

Overview:
Drains the timestamp queues of the RX and TX tsu instances through one read port each. Presents the captured entries as a single valid/ready stream tagged with their source. Sits in the q_rd_clk domain between the two tsu queue read interfaces and the host/CPU register bridge. Sequences each queue read (rd_en pulse, fixed read latency, capture) and arbitrates when both queues hold entries.

Parameters:
DATA_W, 56, width of q_rd_data from each tsu queue
STAT_W, 8, width of q_rd_stat (queue occupancy count)
RD_LAT, 1, cycles from rd_en-high cycle to q_rd_data valid; legal 1..4
CNT_W, 16, width of per-source drained-entry counters

Ports:
q_rd_clk  in  1  single clock, rising edge
q_rst  in  1  synchronous reset, active-high
rx_q_rd_stat  in  STAT_W  RX queue occupancy; 0 = empty
rx_q_rd_data  in  DATA_W  RX queue read data
rx_q_rd_en  out  1  RX queue read strobe, one-cycle pulse
tx_q_rd_stat  in  STAT_W  TX queue occupancy; 0 = empty
tx_q_rd_data  in  DATA_W  TX queue read data
tx_q_rd_en  out  1  TX queue read strobe, one-cycle pulse
out_valid  out  1  out_data/out_src hold a captured entry
out_ready  in  1  consumer accepts entry when high with out_valid
out_src  out  1  0 = RX queue, 1 = TX queue
out_data  out  DATA_W  captured timestamp entry
rx_cnt  out  CNT_W  RX entries delivered, wraps
tx_cnt  out  CNT_W  TX entries delivered, wraps

Behaviour:
- Clock and reset: single clock q_rd_clk; q_rst is synchronous, active-high.
- Reset values (q_rst high at a rising edge): rx_q_rd_en=0, tx_q_rd_en=0, out_valid=0, out_src=0, out_data=0, rx_cnt=0, tx_cnt=0; FSM=IDLE; round-robin pointer=RX.
- FSM states: IDLE, RD, WAIT, HOLD.
- IDLE:
  - Sample both stat inputs; a source requests when its stat != 0.
  - One requester: select it.
  - Both requesting: select the source named by the RR pointer.
  - Any request: go to RD and latch the selection. Otherwise stay in IDLE.
- RD: exactly one cycle. Selected rd_en=1, the other rd_en=0. Go to WAIT with wait counter = RD_LAT-1.
- WAIT:
  - Counts down; all rd_en=0.
  - When the counter is 0, sample the selected source's q_rd_data into out_data and set out_src. out_valid=1 from the next cycle. Go to HOLD.
  - Latency: rd_en in cycle c -> data sampled at end of cycle c+RD_LAT -> out_valid high in cycle c+RD_LAT+1. With RD_LAT=1: IDLE request cycle n, rd_en cycle n+1, out_valid cycle n+3.
- HOLD:
  - out_valid=1. out_data and out_src are stable until the handshake.
  - On out_valid && out_ready at a rising edge: out_valid=0 next cycle, increment the selected source's counter, set the RR pointer to the other source, go to IDLE.
- Read rate: minimum spacing between rd_en pulses is RD_LAT+3 cycles. Queue stat therefore has at least RD_LAT+1 cycles to reflect a read before it is re-sampled; no queue is read while empty.
- Never assert both rd_en together. Never assert rd_en outside RD.
- Backpressure: out_ready low holds the FSM in HOLD indefinitely; no further reads are issued.
- stat changes outside IDLE are ignored until the next IDLE cycle.
- Counters wrap 2^CNT_W-1 -> 0 silently.
- q_rst in RD/WAIT/HOLD aborts immediately to reset values. An entry already popped from a queue is discarded, by design.

Optional Feature:
- Macro: TSU_ARB_TX_PRIO_EN.
- Defined: strict priority. When both stat != 0 in IDLE, TX is always selected; the RR pointer is unused and held at RX.
- Undefined: round-robin as above.
- Single-requester behaviour and latency are identical in both builds.

Test Plan:
- Reset: drive q_rst high 2 cycles with both stats=3 -> both rd_en=0, out_valid=0, rx_cnt=tx_cnt=0; first rx_q_rd_en appears 2 cycles after q_rst falls (IDLE cycle, then RD).
- Single RX entry (RD_LAT=1): rx stat 0->1, rx data 56'h00_1234_5678_9ABC in the cycle after rd_en, out_ready=1 -> one rx_q_rd_en pulse, out_valid 3 cycles after request, out_src=0, out_data=56'h00_1234_5678_9ABC, rx_cnt=1, no tx_q_rd_en.
- Both queues stat=2, out_ready=1, round-robin build -> read order RX,TX,RX,TX; rx_cnt=2, tx_cnt=2. With TSU_ARB_TX_PRIO_EN -> order TX,TX,RX,RX.
- Backpressure: out_ready=0 for 20 cycles with out_valid=1 -> out_data/out_src stable, no rd_en pulses, counters unchanged; out_ready=1 -> accept, out_valid drops next cycle.
- RD_LAT=3: TX entry with data valid exactly 3 cycles after rd_en cycle, garbage on the other cycles -> captured value equals the cycle-3 data; out_valid 4 cycles after rd_en.
- Wrap and reset mid-op: preload 65535 RX deliveries -> next delivery gives rx_cnt=0; q_rst asserted during WAIT -> out_valid stays 0, FSM restarts from IDLE.
